// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding RAM access per request, with width/sign handling and a WAIT timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of issuing them.
module load_store_unit #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_base,
  input  logic [11:0]       req_offset,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_oplen,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      ea;
  logic [1:0]       oplen_req;
  logic             misalign;
  logic             illegal;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic [31:0]      load_ext;

  always_comb begin
    ea = req_base + {{20{req_offset[11]}}, req_offset};
    unique case (req_funct3[1:0])
      2'b00:   oplen_req = 2'b00;
      2'b01:   oplen_req = 2'b01;
      default: oplen_req = 2'b11;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((oplen_req == 2'b01) && ea[0]) ||
               ((oplen_req == 2'b11) && (ea[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    illegal = ((ea >> ADDR_W) != 32'd0) || misalign;
    if (req_store && (req_funct3 > 3'd2)) illegal = 1'b1;
    if (!req_store && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111)))
      illegal = 1'b1;
  end

  // Upper bytes of mem_rdata beyond the access width never reach rsp_data.
  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  load_ext = {24'd0, mem_rdata[7:0]};
      3'b101:  load_ext = {16'd0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  assign timeout = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid) state_next = illegal ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (mem_valid || timeout) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so it reads 0 for the whole reset interval.
  always_comb begin
    req_ready  = (state == IDLE) && rst_n;
    mem_enable = (state == ISSUE);
    rsp_valid  = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_oplen <= '0;
      mem_wdata <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      cnt       <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            if (illegal) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
              rsp_rd   <= req_store ? 5'd0 : req_rd;
            end else begin
              mem_addr  <= ea[ADDR_W-1:0];
              mem_we    <= req_store;
              mem_oplen <= oplen_req;
              mem_wdata <= req_wdata;
              funct3_q  <= req_funct3;
              rd_q      <= req_rd;
            end
          end
        end
        WAIT: begin
          if (mem_valid) begin
            rsp_err  <= 1'b0;
            rsp_data <= mem_we ? 32'd0 : load_ext;
            rsp_rd   <= mem_we ? 5'd0 : rd_q;
          end else if (timeout) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
            rsp_rd   <= mem_we ? 5'd0 : rd_q;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level reference model and a per-cycle compare process.
module tb_load_store_unit;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned TO     = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_base = '0;
  logic [11:0]       req_offset = '0;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [31:0]       req_wdata = '0;
  logic [4:0]        req_rd = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_err;
  logic              mem_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_oplen;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_valid = 1'b0;
  logic [31:0]       mem_rdata = '0;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_offset(req_offset),
    .req_store(req_store), .req_funct3(req_funct3), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_err(rsp_err), .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_oplen(mem_oplen),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected transaction, filled by predict()
  bit                exp_busy = 1'b0;
  bit                exp_issue;
  bit                exp_timeout;
  logic [ADDR_W-1:0] exp_addr;
  logic [1:0]        exp_oplen;
  bit                exp_we;
  logic [31:0]       exp_wdata;
  logic [31:0]       exp_data;
  logic [4:0]        exp_rd;
  bit                exp_err;

  // Observations from the compare process
  int                cyc = 0;
  int                n_enable = 0;
  int                n_rsp_cycles = 0;
  int                enable_cyc = 0;
  int                rsp_cyc = 0;
  bit                in_flight = 1'b0;
  logic [ADDR_W-1:0] last_addr;
  logic [1:0]        last_oplen;
  logic              last_we;
  logic [31:0]       last_wdata;
  logic [31:0]       last_rsp_data;
  logic              last_rsp_err;

  // Memory responder knobs
  int                lat = 1;
  bit                spurious = 1'b0;
  logic [31:0]       resp_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic predict(input logic [31:0] base, input logic [11:0] off, input bit st,
                         input logic [2:0] f3, input logic [31:0] wd, input logic [4:0] rd,
                         input int l, input logic [31:0] rdata);
    longint ea_l, v, span;
    logic [31:0] ea;
    int bytes;
    bit bad;
    ea_l  = (longint'(base) + longint'($signed(off))) & 64'h0000_0000_FFFF_FFFF;
    ea    = 32'(ea_l);
    bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad   = longint'(ea) >= (longint'(1) << ADDR_W);
    if (st && (f3 > 3'd2)) bad = 1'b1;
    if (!st && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7))) bad = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((longint'(ea) % bytes) != 0) bad = 1'b1;
`endif
    exp_issue   = !bad;
    exp_timeout = (l == 0) || (l > int'(TO));
    exp_addr    = ea[ADDR_W-1:0];
    exp_oplen   = (bytes == 1) ? 2'd0 : (bytes == 2) ? 2'd1 : 2'd3;
    exp_we      = st;
    exp_wdata   = wd;
    exp_rd      = st ? 5'd0 : rd;
    exp_err     = bad || exp_timeout;
    exp_data    = 32'd0;
    if (!exp_err && !st) begin
      span = longint'(1) << (8 * bytes);
      v    = longint'(rdata) % span;
      if (!f3[2] && (bytes < 4) && (v >= span / 2)) v = v - span;
      exp_data = 32'(v);
    end
  endtask

  task automatic drive_req(input logic [31:0] base, input logic [11:0] off, input bit st,
                           input logic [2:0] f3, input logic [31:0] wd, input logic [4:0] rd);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 40) begin @(negedge clk); w++; end
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_base = base; req_offset = off; req_store = st;
    req_funct3 = f3; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_base = $urandom; req_offset = 12'($urandom); req_store = 1'($urandom);
    req_funct3 = 3'($urandom); req_wdata = $urandom; req_rd = 5'($urandom);
  endtask

  task automatic run_txn(input logic [31:0] base, input logic [11:0] off, input bit st,
                         input logic [2:0] f3, input logic [31:0] wd, input logic [4:0] rd,
                         input int l, input logic [31:0] rdata, input int hold, input bit spur);
    int w = 0;
    predict(base, off, st, f3, wd, rd, l, rdata);
    lat = l; resp_rdata = rdata; spurious = spur;
    n_enable = 0; n_rsp_cycles = 0; exp_busy = 1'b1;
    drive_req(base, off, st, f3, wd, rd);
    while (!rsp_valid && w < int'(TO) + 10) begin @(negedge clk); w++; end
    check("rsp_valid_arrives", 64'(rsp_valid), 64'd1);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_dropped", 64'(rsp_valid), 64'd0);
    check("req_ready_after_rsp", 64'(req_ready), 64'd1);
    check("enable_count", 64'(n_enable), exp_issue ? 64'd1 : 64'd0);
    check("resp_cycles", 64'(n_rsp_cycles), 64'(hold + 1));
    if (exp_issue)
      check("latency", 64'(rsp_cyc - enable_cyc), 64'(exp_timeout ? int'(TO) + 1 : l + 1));
    exp_busy = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_rd", 64'(rsp_rd), 64'd0);
    check("rst_mem_enable", 64'(mem_enable), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_oplen", 64'(mem_oplen), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
  endtask

  // Memory responder: mem_valid pulses in WAIT cycle `lat` (1-based); lat=0 never answers.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_enable) begin
        mem_valid = spurious;
        mem_rdata = $urandom;
        for (int k = 1; k <= lat; k++) begin
          @(negedge clk);
          mem_valid = (k == lat);
          mem_rdata = (k == lat) ? resp_rdata : $urandom;
        end
        @(negedge clk);
        mem_valid = 1'b0;
      end
    end
  end

  // Compare process
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        in_flight = 1'b0;
      end else begin
        if (mem_enable) begin
          n_enable++;
          enable_cyc = cyc;
          in_flight  = 1'b1;
          check("mem_enable_allowed", 64'(exp_busy && exp_issue), 64'd1);
          check("mem_addr", 64'(mem_addr), 64'(exp_addr));
          check("mem_oplen", 64'(mem_oplen), 64'(exp_oplen));
          check("mem_we", 64'(mem_we), 64'(exp_we));
          check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
          last_addr = mem_addr; last_oplen = mem_oplen; last_we = mem_we; last_wdata = mem_wdata;
        end else if (in_flight && !rsp_valid) begin
          check("mem_addr_hold", 64'(mem_addr), 64'(exp_addr));
          check("mem_oplen_hold", 64'(mem_oplen), 64'(exp_oplen));
          check("mem_we_hold", 64'(mem_we), 64'(exp_we));
          check("mem_wdata_hold", 64'(mem_wdata), 64'(exp_wdata));
        end
        if (rsp_valid) begin
          if (n_rsp_cycles == 0) rsp_cyc = cyc;
          n_rsp_cycles++;
          in_flight = 1'b0;
          check("rsp_allowed", 64'(exp_busy), 64'd1);
          check("rsp_data", 64'(rsp_data), 64'(exp_data));
          check("rsp_rd", 64'(rsp_rd), 64'(exp_rd));
          check("rsp_err", 64'(rsp_err), 64'(exp_err));
          check("req_ready_in_resp", 64'(req_ready), 64'd0);
          last_rsp_data = rsp_data; last_rsp_err = rsp_err;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rb;
    int rl;
    int sel;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("req_ready_after_reset", 64'(req_ready), 64'd1);

    // LB with negative offset
    run_txn(32'h20, 12'hFFC, 1'b0, 3'b000, 32'h0, 5'd7, 3, 32'h0000_00F0, 0, 1'b0);
    check("lb_addr_lit", 64'(last_addr), 64'h1C);
    check("lb_oplen_lit", 64'(last_oplen), 64'd0);
    check("lb_data_lit", 64'(last_rsp_data), 64'hFFFF_FFF0);
    check("lb_err_lit", 64'(last_rsp_err), 64'd0);

    // SW
    run_txn(32'h40, 12'h000, 1'b1, 3'b010, 32'h0415_2023, 5'd9, 2, 32'hDEAD_BEEF, 1, 1'b1);
    check("sw_enables_lit", 64'(n_enable), 64'd1);
    check("sw_we_lit", 64'(last_we), 64'd1);
    check("sw_oplen_lit", 64'(last_oplen), 64'd3);
    check("sw_wdata_lit", 64'(last_wdata), 64'h0415_2023);
    check("sw_err_lit", 64'(last_rsp_err), 64'd0);

    // LW that never completes, then a normal one
    run_txn(32'h80, 12'h004, 1'b0, 3'b010, 32'h0, 5'd3, 0, 32'h0, 0, 1'b0);
    check("to_err_lit", 64'(last_rsp_err), 64'd1);
    check("to_data_lit", 64'(last_rsp_data), 64'd0);
    check("to_wait_lit", 64'(rsp_cyc - enable_cyc), 64'd16);
    run_txn(32'h80, 12'h004, 1'b0, 3'b010, 32'h0, 5'd3, 1, 32'h1234_5678, 0, 1'b0);
    check("after_to_data_lit", 64'(last_rsp_data), 64'h1234_5678);

    // LH at an odd address
    run_txn(32'h21, 12'h000, 1'b0, 3'b001, 32'h0, 5'd4, 2, 32'h0000_7FFE, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh_odd_err_lit", 64'(last_rsp_err), 64'd1);
    check("lh_odd_enables_lit", 64'(n_enable), 64'd0);
`else
    check("lh_odd_addr_lit", 64'(last_addr), 64'h21);
    check("lh_odd_err_lit", 64'(last_rsp_err), 64'd0);
`endif

    // LHU with upper junk and a stalled writeback
    run_txn(32'h100, 12'h002, 1'b0, 3'b101, 32'h0, 5'd12, 2, 32'hABCD_8001, 3, 1'b0);
    check("lhu_data_lit", 64'(last_rsp_data), 64'h0000_8001);
    check("lhu_cycles_lit", 64'(n_rsp_cycles), 64'd4);

    // Boundaries: timeout edge, address range edge, illegal encodings
    run_txn(32'h200, 12'h000, 1'b0, 3'b000, 32'h0, 5'd1, int'(TO), 32'h0000_0080, 0, 1'b0);
    run_txn(32'h200, 12'h000, 1'b0, 3'b000, 32'h0, 5'd1, int'(TO) + 1, 32'h0000_0080, 0, 1'b0);
    run_txn(32'h01FF_FFFF, 12'h000, 1'b0, 3'b100, 32'h0, 5'd2, 1, 32'h0000_00FF, 0, 1'b0);
    run_txn(32'h01FF_FFFF, 12'h001, 1'b0, 3'b100, 32'h0, 5'd2, 1, 32'h0000_00FF, 0, 1'b0);
    run_txn(32'h0200_0000, 12'hFFF, 1'b1, 3'b000, 32'hA5, 5'd2, 1, 32'h0, 0, 1'b0);
    run_txn(32'h300, 12'h000, 1'b0, 3'b011, 32'h0, 5'd5, 1, 32'h0, 1, 1'b0);
    run_txn(32'h300, 12'h000, 1'b1, 3'b100, 32'h55, 5'd5, 1, 32'h0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 3));
      rb  = (sel == 0) ? $urandom : ($urandom & 32'h01FF_FFFF);
      sel = int'($urandom_range(0, 7));
      rl  = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(13, 16)) : int'($urandom_range(1, 4));
      run_txn(rb, 12'($urandom), 1'($urandom), 3'($urandom), $urandom, 5'($urandom),
              rl, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset in the middle of WAIT drops the request
    predict(32'h100, 12'h000, 1'b0, 3'b010, 32'h0, 5'd3, 0, 32'h0);
    lat = 0; spurious = 1'b0; n_enable = 0; n_rsp_cycles = 0; exp_busy = 1'b1;
    drive_req(32'h100, 12'h000, 1'b0, 3'b010, 32'h0, 5'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_busy = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("req_ready_after_mid_reset", 64'(req_ready), 64'd1);
    repeat (20) @(negedge clk);
    check("no_rsp_after_reset", 64'(n_rsp_cycles), 64'd0);
    check("mid_reset_enables", 64'(n_enable), 64'd1);
    run_txn(32'h44, 12'h000, 1'b0, 3'b001, 32'h0, 5'd8, 2, 32'h0000_8000, 0, 1'b0);
    check("post_reset_lh_lit", 64'(last_rsp_data), 64'hFFFF_8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
